// File: rtl/prefetch_unit_pkg.sv
// Shared fetch-side constants and the fetch control state type for the prefetch unit.
package prefetch_unit_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_STEP = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FS_DISC: a request is still outstanding but its response belongs to a
  // stream that was redirected away and must be dropped.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_PEND = 2'd1,
    FS_DISC = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/prefetch_unit_fifo.sv
// Instruction queue for the prefetch unit: DEPTH entries of {pc, word}, synchronous
// push/pop/flush; the read port holds the last head contents while empty.
module prefetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Track the live head so the outputs freeze on it once the queue drains.
    last_d = empty ? last_q : mem_q[rd_ptr_q];
    rdata  = empty ? last_q : mem_q[rd_ptr_q];
    count  = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches with one request in
// flight, queues returned words, and handles redirects by flushing and discarding.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            reset,
  // Memory side: a request transfers when mem_req && mem_ready; mem_rvalid
  // returns data for the single outstanding request. Core side: the head
  // transfers when instr_valid && instr_ready.
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            jump_branch_enable,
  input  logic [XLEN-1:0] jump_address,
  output logic [CW-1:0]   queue_count,
  output fetch_state_e    dbg_state
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              pending, discard, rsp, accept;
  logic              push, pop, flush;
  logic [CW:0]       occupancy;
  logic [2*XLEN-1:0] head;
  logic              fifo_full, fifo_empty;

  always_comb begin
    pending   = (state_q != FS_IDLE);
    discard   = (state_q == FS_DISC);
    rsp       = pending && mem_rvalid;
    // The in-flight request reserves a slot so a full queue can never overflow.
    occupancy = {1'b0, queue_count} + (CW+1)'(pending);
    mem_req   = !reset && !jump_branch_enable &&
                (occupancy < (CW+1)'(DEPTH)) && (!pending || mem_rvalid);
    accept    = mem_req && mem_ready;
    flush     = jump_branch_enable;
    push      = rsp && !discard && !jump_branch_enable;
    instr_valid = !fifo_empty;
    pop       = instr_valid && instr_ready && !jump_branch_enable;
    mem_addr  = fetch_pc_q;
    {instr_pc, instr} = head;
    dbg_state = state_q;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      FS_IDLE: if (accept) state_d = FS_PEND;
      FS_PEND: begin
        if (mem_rvalid)              state_d = accept ? FS_PEND : FS_IDLE;
        else if (jump_branch_enable) state_d = FS_DISC;
      end
      FS_DISC: if (mem_rvalid) state_d = accept ? FS_PEND : FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
    if (accept) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_STEP);
    end
    if (jump_branch_enable) fetch_pc_d = {jump_address[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  prefetch_unit_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN),
    .CW    (CW)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({req_pc_q, mem_rdata}),
    .rdata (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit: directed scenarios, a latency-programmable
// memory responder, and monitors that pop expected requests and instructions.
module tb_prefetch_unit;
  import prefetch_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic            mem_ready = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            instr_ready = 1'b0;
  logic            jump_branch_enable = 1'b0;
  logic [XLEN-1:0] jump_address = '0;

  wire             mem_req, instr_valid;
  wire [XLEN-1:0]  mem_addr, instr, instr_pc;
  wire [CW-1:0]    queue_count;
  fetch_state_e    dbg_state;

  wire             u1_mem_req, u1_instr_valid;
  wire [XLEN-1:0]  u1_mem_addr, u1_instr, u1_instr_pc;
  wire [CW-1:0]    u1_queue_count;
  fetch_state_e    u1_dbg_state;

  logic [2*XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]   exp_addr_q[$];
  logic [XLEN-1:0]   exp_addr1_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int rsp_lat = 1;

  logic            out_valid = 1'b0;
  logic [XLEN-1:0] out_addr = '0;
  int              out_wait = 0;

  prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .jump_branch_enable(jump_branch_enable),
    .jump_address(jump_address), .queue_count(queue_count), .dbg_state(dbg_state)
  );

  prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .CLK(CLK), .reset(reset), .mem_req(u1_mem_req), .mem_addr(u1_mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(u1_instr_valid), .instr(u1_instr), .instr_pc(u1_instr_pc),
    .instr_ready(instr_ready), .jump_branch_enable(jump_branch_enable),
    .jump_address(jump_address), .queue_count(u1_queue_count), .dbg_state(u1_dbg_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [XLEN-1:0] mk_word(input logic [XLEN-1:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Memory model: one response per accepted request, rsp_lat cycles later.
  initial begin
    forever begin
      @(negedge CLK);
      if (mem_rvalid) out_valid = 1'b0;
      if (mem_req && mem_ready && !reset) begin
        out_valid = 1'b1;
        out_addr  = mem_addr;
        out_wait  = rsp_lat;
      end
      @(posedge CLK);
      #1;
      mem_rvalid = 1'b0;
      if (out_valid) begin
        out_wait--;
        if (out_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mk_word(out_addr);
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] e;
    forever begin
      @(negedge CLK);
      if (!reset && mem_req && mem_ready && exp_addr_q.size() > 0) begin
        e = exp_addr_q.pop_front();
        chk("req_addr", mem_addr, e);
      end
    end
  end

  initial begin
    logic [XLEN-1:0] e;
    forever begin
      @(negedge CLK);
      if (!reset && u1_mem_req && mem_ready && exp_addr1_q.size() > 0) begin
        e = exp_addr1_q.pop_front();
        chk("req_addr_hi", u1_mem_addr, e);
      end
    end
  end

  initial begin
    logic [2*XLEN-1:0] e;
    forever begin
      @(negedge CLK);
      if (!reset && instr_valid && instr_ready && !jump_branch_enable && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e[2*XLEN-1:XLEN]);
        chk("instr", instr, e[XLEN-1:0]);
      end
    end
  end

  task automatic exp_instr(input logic [XLEN-1:0] pc);
    exp_q.push_back({pc, mk_word(pc)});
  endtask

  task automatic start_test();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    jump_branch_enable = 1'b0;
  endtask

  task automatic release_reset();
    repeat (4) next_cycle();
    @(negedge CLK);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_queue_count", 32'(queue_count), 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_addr_hi", u1_mem_addr, 32'hFFFF_FFF8);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(FS_IDLE));
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && exp_addr_q.size() == 0 && exp_addr1_q.size() == 0) break;
      @(negedge CLK);
    end
    chk({tag, "_instr_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_addr_left"}, 32'(exp_addr_q.size()), 0);
    chk({tag, "_addr_hi_left"}, 32'(exp_addr1_q.size()), 0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_addr1_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Zero-wait streaming, plus the wrap-around reset PC on the second instance.
    start_test();
    rsp_lat = 1; mem_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(32'(4 * i));
      exp_instr(32'(4 * i));
    end
    exp_addr1_q.push_back(32'hFFFF_FFF8);
    exp_addr1_q.push_back(32'hFFFF_FFFC);
    exp_addr1_q.push_back(32'h0000_0000);
    exp_addr1_q.push_back(32'h0000_0004);
    release_reset();
    @(negedge CLK);
    chk("t1_c0_req", 32'(mem_req), 1);
    chk("t1_c0_valid", 32'(instr_valid), 0);
    next_cycle();
    @(negedge CLK);
    chk("t1_c1_addr", mem_addr, 32'h4);
    chk("t1_c1_valid", 32'(instr_valid), 0);
    next_cycle();
    @(negedge CLK);
    chk("t1_c2_valid", 32'(instr_valid), 1);
    chk("t1_c2_pc", instr_pc, 32'h0);
    chk("t1_c2_addr", mem_addr, 32'h8);
    drain("t1");

    // Fill to DEPTH with the core stalled, then release.
    start_test();
    rsp_lat = 1; mem_ready = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_addr_q.push_back(32'(4 * i));
      exp_instr(32'(4 * i));
    end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (queue_count == CW'(4)) break;
    end
    chk("t2_full_count", 32'(queue_count), 4);
    chk("t2_full_req", 32'(mem_req), 0);
    chk("t2_full_addr", mem_addr, 32'h10);
    next_cycle();
    @(negedge CLK);
    chk("t2_full_req2", 32'(mem_req), 0);
    next_cycle();
    instr_ready = 1'b1;
    drain("t2");

    // Redirect while the request for 0x8 is outstanding.
    start_test();
    rsp_lat = 3; mem_ready = 1'b1; instr_ready = 1'b0;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    exp_instr(32'h100);
    exp_instr(32'h104);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (mem_req && mem_ready && mem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_found_req8", 32'(found), 1);
    next_cycle();
    jump_branch_enable = 1'b1;
    jump_address = 32'h0000_0103;
    @(negedge CLK);
    chk("t3_jmp_req", 32'(mem_req), 0);
    next_cycle();
    jump_branch_enable = 1'b0;
    @(negedge CLK);
    chk("t3_flush_count", 32'(queue_count), 0);
    chk("t3_flush_valid", 32'(instr_valid), 0);
    chk("t3_disc_req", 32'(mem_req), 0);
    chk("t3_target_addr", mem_addr, 32'h100);
    chk("t3_hold_pc", instr_pc, 32'h0);
    chk("t3_state", 32'(dbg_state), 32'(FS_DISC));
    next_cycle();
    @(negedge CLK);
    chk("t3_rsp_req", 32'(mem_req), 1);
    chk("t3_rsp_addr", mem_addr, 32'h100);
    next_cycle();
    @(negedge CLK);
    chk("t3_dropped_count", 32'(queue_count), 0);
    next_cycle();
    instr_ready = 1'b1;
    drain("t3");

    // Memory stall: request and address hold.
    start_test();
    rsp_lat = 1; mem_ready = 1'b0; instr_ready = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_instr(32'h0);
    exp_instr(32'h4);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t4_stall_req", 32'(mem_req), 1);
      chk("t4_stall_addr", mem_addr, 32'h0);
      next_cycle();
    end
    mem_ready = 1'b1;
    drain("t4");

    // Reset with a request in flight; the late response must be ignored.
    start_test();
    rsp_lat = 2; mem_ready = 1'b1; instr_ready = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_instr(32'h0);
    release_reset();
    @(negedge CLK);
    chk("t5_c0_state_req", 32'(mem_req), 1);
    next_cycle();
    reset = 1'b1;
    @(negedge CLK);
    chk("t5_rst_count", 32'(queue_count), 0);
    next_cycle();
    reset = 1'b0;
    @(negedge CLK);
    chk("t5_stray_rvalid", 32'(mem_rvalid), 1);
    chk("t5_post_req", 32'(mem_req), 1);
    chk("t5_post_addr", mem_addr, 32'h0);
    chk("t5_post_count", 32'(queue_count), 0);
    next_cycle();
    @(negedge CLK);
    chk("t5_no_push", 32'(queue_count), 0);
    drain("t5");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: Prefetch_Unit

Interface
REQ-001 Parameter XLEN, default 32: address/instruction width.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  instruction-memory read request valid.
REQ-007 mem_addr  output  XLEN  word-aligned request address.
REQ-008 mem_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_rvalid  input  1  read data valid for the oldest accepted request.
REQ-010 mem_rdata  input  XLEN  returned instruction word.
REQ-011 instr_valid  output  1  queue head holds a valid instruction.
REQ-012 instr  output  XLEN  head instruction word.
REQ-013 instr_pc  output  XLEN  address of the head instruction.
REQ-014 instr_ready  input  1  core consumes the head this cycle.
REQ-015 jump_branch_enable  input  1  one-cycle redirect strobe.
REQ-016 jump_address  input  XLEN  redirect target; bits [1:0] are ignored (treated as 0).
REQ-017 queue_count  output  $clog2(DEPTH+1)  valid entries currently held.

Function
REQ-018 The block SHALL keep fetch_pc; mem_addr = fetch_pc at all times.
REQ-019 At most one request SHALL be outstanding (pending flag).
REQ-020 mem_req SHALL be high iff !reset && !jump_branch_enable && (queue_count + pending < DEPTH) && (!pending || mem_rvalid).
REQ-021 Handshake: a request is accepted when mem_req && mem_ready; then pending <= 1 and fetch_pc <= fetch_pc + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x0).
REQ-022 mem_req and mem_addr SHALL stay stable until accepted, unless a redirect occurs.
REQ-023 On mem_rvalid with pending && !discard, {fetch address, mem_rdata} SHALL be pushed into the queue; pending clears unless a new request is accepted the same cycle.
REQ-024 mem_rvalid with !pending SHALL be ignored.
REQ-025 instr_valid = (queue_count != 0); pop on instr_valid && instr_ready; push and pop in one cycle leave queue_count unchanged.
REQ-026 The queue SHALL be FIFO order; read/write pointers wrap modulo DEPTH.
REQ-027 Zero-wait memory (mem_ready = 1, mem_rvalid one cycle after acceptance) SHALL sustain one instruction per cycle; first instr_valid two cycles after reset deasserts.
REQ-028 Redirect: when jump_branch_enable is high, the queue SHALL be flushed (queue_count <= 0), fetch_pc <= {jump_address[XLEN-1:2], 2'b00}, and any pop or push that cycle is discarded.
REQ-029 If a request is pending at redirect and mem_rvalid is not high that cycle, discard <= 1; the next mem_rvalid clears pending and discard without pushing.
REQ-030 While discard is set, mem_req SHALL be asserted only in the cycle mem_rvalid arrives, so the first post-redirect request is at the jump target.
REQ-031 Back-to-back redirects: the last one wins; discard stays set until the single outstanding response returns.
REQ-032 When the queue is full, mem_req SHALL be low; no overflow is possible.
REQ-033 When instr_valid is 0, instr and instr_pc SHALL hold the last head contents (reset value 0).

Reset
REQ-034 While reset is high: fetch_pc = RESET_PC, pending = 0, discard = 0, pointers = 0, queue_count = 0, mem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-035 Reset asserted mid-transaction SHALL drop the outstanding request; a mem_rvalid arriving after reset SHALL be ignored by REQ-024.

Structure
REQ-036 The XLEN default, the instruction step (4), and the reset-PC default SHALL live in the shared core defines include used by the fetch and control logic.
REQ-037 Storage SHALL be one sub-module, Prefetch_FIFO (DEPTH x 2*XLEN, synchronous push/pop/flush, count output); pending/discard/fetch_pc control stays in Prefetch_Unit.

Verification
REQ-038 Reset release, mem_ready = 1, rvalid after 1 cycle, instr_ready = 1 -> mem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_pc 0x0 valid at cycle 2, then one per cycle.
REQ-039 instr_ready = 0, DEPTH = 4 -> queue_count reaches 4, mem_req low; raise instr_ready -> pops 0x0..0xC in order, fetching resumes at 0x10.
REQ-040 Redirect to 0x103 while the request for 0x8 is pending, rvalid two cycles later -> 0x8 data dropped, queue empty, next request at 0x100, instr_pc 0x100 is the first valid output.
REQ-041 RESET_PC = 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-042 mem_ready low for 3 cycles -> mem_req and mem_addr held stable, no pc advance.
REQ-043 Reset asserted with a request pending, stray rvalid the next cycle -> queue_count stays 0, first post-reset request at RESET_PC.
